vdg_pixel_serializer: RTL

Converts decoded character-cell data into a pixel stream for the Dragon VDG replacement. Takes 8-bit pixel patterns and a 4-bit foreground colour from the semigraphics/alpha decode stage through a ready/valid handshake. Emits one colour index per pixel-clock enable, MSB first. Also owns the per-cell row counter that drives the decode stage's row input, and flags underruns.

---
 rtl/vdg_pkg.sv | 19 +
 rtl/vdg_row_counter.sv | 31 +++
 rtl/vdg_pixel_serializer.sv | 114 +++++++++++
 3 files changed

// File: rtl/vdg_pkg.sv
// Shared types and constants for the VDG replacement pixel path.
package vdg_pkg;

    typedef logic [3:0] vdg_colour_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ser_state_t;

    localparam vdg_colour_t VDG_BLACK         = 4'd0;
    localparam int          VDG_ROWS_PER_CELL = 12;

    // A set pattern bit shows the cell's foreground colour; a clear bit is black.
    function automatic vdg_colour_t pix_sel(input logic bit_on, input vdg_colour_t colour);
        return bit_on ? colour : VDG_BLACK;
    endfunction

endpackage

// File: rtl/vdg_row_counter.sv
// Scanline-within-cell counter feeding the decode stage's row input.
module vdg_row_counter
    import vdg_pkg::*;
#(
    parameter int ROWS_PER_CELL = VDG_ROWS_PER_CELL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lineEnd,
    input  logic       frameStart,
    output logic [3:0] cellRow
);

    localparam logic [3:0] ROW_LAST = 4'(ROWS_PER_CELL - 1);

    logic [3:0] r_row;

    // frameStart outranks the lineEnd increment so a field always begins on row 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row <= 4'd0;
        end else if (frameStart) begin
            r_row <= 4'd0;
        end else if (lineEnd) begin
            r_row <= (r_row == ROW_LAST) ? 4'd0 : r_row + 4'd1;
        end
    end

    assign cellRow = r_row;

endmodule

// File: rtl/vdg_pixel_serializer.sv
// Double-buffered pattern shifter: hold register feeds an MSB-first shifter
// emitting one colour index per pixel enable, plus row counting and underrun.
module vdg_pixel_serializer
    import vdg_pkg::*;
#(
    parameter int PIX_BITS      = 8,
    parameter int ROWS_PER_CELL = VDG_ROWS_PER_CELL
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pixEn,
    input  logic                lineStart,
    input  logic                lineEnd,
    input  logic                frameStart,
    input  logic [PIX_BITS-1:0] loadData,
    input  logic [3:0]          loadColour,
    input  logic                loadValid,
    output logic                loadReq,
    output logic [3:0]          pixColour,
    output logic [3:0]          cellRow,
    output logic                underrun
);

    localparam int               CNT_W    = $clog2(PIX_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_BITS - 1);

    ser_state_t          r_state;
    logic [PIX_BITS-1:0] r_hold_data;
    vdg_colour_t         r_hold_colour;
    logic                r_hold_full;
    logic [PIX_BITS-1:0] r_sh_reg;
    vdg_colour_t         r_sh_colour;
    logic [CNT_W-1:0]    r_bit_cnt;
    vdg_colour_t         r_pix_colour;
    logic                r_underrun;

    logic                w_load_acc;
    logic                w_step;

    assign loadReq    = !r_hold_full;
    assign w_load_acc = loadValid && loadReq;
    assign w_step     = (r_state == ST_ACTIVE) && pixEn;

    // Line control, shifter and hold register; lineEnd flushes everything and wins over lineStart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_hold_data   <= {PIX_BITS{1'b0}};
            r_hold_colour <= VDG_BLACK;
            r_hold_full   <= 1'b0;
            r_sh_reg      <= {PIX_BITS{1'b0}};
            r_sh_colour   <= VDG_BLACK;
            r_bit_cnt     <= {CNT_W{1'b0}};
            r_pix_colour  <= VDG_BLACK;
            r_underrun    <= 1'b0;
        end else begin
            if (lineEnd) begin
                r_state      <= ST_IDLE;
                r_hold_full  <= 1'b0;
                r_sh_reg     <= {PIX_BITS{1'b0}};
                r_sh_colour  <= VDG_BLACK;
                r_bit_cnt    <= {CNT_W{1'b0}};
                r_pix_colour <= VDG_BLACK;
            end else begin
                if (lineStart) begin
                    // A restart drops the partial pattern but keeps any prefetched byte.
                    r_state      <= ST_ACTIVE;
                    r_sh_reg     <= {PIX_BITS{1'b0}};
                    r_bit_cnt    <= {CNT_W{1'b0}};
                    r_pix_colour <= VDG_BLACK;
                end else if (w_step) begin
                    if (r_bit_cnt != {CNT_W{1'b0}}) begin
                        r_pix_colour <= pix_sel(r_sh_reg[PIX_BITS-1], r_sh_colour);
                        r_sh_reg     <= {r_sh_reg[PIX_BITS-2:0], 1'b0};
                        r_bit_cnt    <= (r_bit_cnt == CNT_LAST) ? {CNT_W{1'b0}}
                                                                : r_bit_cnt + CNT_W'(1);
                    end else if (r_hold_full) begin
                        r_pix_colour <= pix_sel(r_hold_data[PIX_BITS-1], r_hold_colour);
                        r_sh_reg     <= {r_hold_data[PIX_BITS-2:0], 1'b0};
                        r_sh_colour  <= r_hold_colour;
                        r_bit_cnt    <= CNT_W'(1);
                        r_hold_full  <= 1'b0;
                    end else begin
                        r_pix_colour <= VDG_BLACK;
                        r_underrun   <= 1'b1;
                    end
                end
                // Written after the transfer so a same-edge load leaves the hold full.
                if (w_load_acc) begin
                    r_hold_data   <= loadData;
                    r_hold_colour <= loadColour;
                    r_hold_full   <= 1'b1;
                end
            end
            if (frameStart) begin
                r_underrun <= 1'b0;
            end
        end
    end

    vdg_row_counter #(
        .ROWS_PER_CELL (ROWS_PER_CELL)
    ) u_row_counter (
        .clk        (clk),
        .reset      (reset),
        .lineEnd    (lineEnd),
        .frameStart (frameStart),
        .cellRow    (cellRow)
    );

    assign pixColour = r_pix_colour;
    assign underrun  = r_underrun;

endmodule
